icache_fill: RTL and testbench

- Line-fill engine directly downstream of the instruction cache's miss output.
- On `pull`, reads one 4-byte line from external quad-SPI flash (fast-read-quad, cmd 0xEB) at the requested tag.
- Buffers the 8 returned nibbles, then replays them to the cache as 8 contiguous `wstrobe_d` cycles on `dread`, which is the burst the cache's offset counter requires.

---
 rtl/icache_fill_pkg.sv | 29 ++
 rtl/icache_fill_phase.sv | 46 ++++
 rtl/icache_fill.sv | 217 +++++++++++++++++++++
 tb/tb_icache_fill.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fill_pkg.sv
// rtl/icache_fill_pkg.sv - shared types and constants for the icache line-fill engine
package icache_fill_pkg;

    // Fill engine states, in transaction order.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        DRAIN,
        GAP
    } state_e;

    localparam logic [7:0] QSPI_CMD_FAST_READ_QUAD = 8'hEB;
    localparam int         NIBBLES_PER_LINE        = 8;

    // SPI periods per state (CMD is single-line bits, the rest are nibbles).
    localparam int CMD_BITS     = 8;
    localparam int ADDR_NIBBLES = 6;
    localparam int MODE_NIBBLES = 2;

    // Counter widths.
    localparam int PHASE_CNT_W = 8;
    localparam int GAP_CNT_W   = 8;
    localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/icache_fill_phase.sv
// rtl/icache_fill_phase.sv - SPI clock generator and per-state period counter
//
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   en_i          high while a shifting state is active; low parks sclk low
//   len_i         number of sclk periods in the current state
//   sclk_o        flash clock, clk/2, low phase first
//   phase_hi_o    current cycle is the sclk high phase (next edge ends a period)
//   last_o        the period ending at the next edge is the state's last one
module qspi_phase
    import icache_fill_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en_i,
    input  logic [PHASE_CNT_W-1:0] len_i,
    output logic                   sclk_o,
    output logic                   phase_hi_o,
    output logic                   last_o
);

    logic                   sclk_q;
    logic [PHASE_CNT_W-1:0] cnt_q;

    assign sclk_o     = sclk_q;
    assign phase_hi_o = en_i & sclk_q;
    assign last_o     = phase_hi_o && (cnt_q == len_i - 1'b1);

    // The count self-clears on the last period, so the next state starts at 0
    // without the FSM having to issue an explicit load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 1'b0;
            cnt_q  <= '0;
        end else if (!en_i) begin
            sclk_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
                cnt_q <= last_o ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - icache miss line fill from quad-SPI flash with 8-nibble replay burst
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   pull, tag           miss request and line address (byte address [PA-1:2])
//   flush_all           abort any fill in progress
//   dread, wstrobe_d    nibble to cache and its valid (contiguous 8-cycle burst)
//   busy                engine not idle
//   spi_cs_n, spi_sclk  flash select and clock
//   spi_io_out/oe/in    flash quad IO drive, per-bit enable, sample
module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int         PA           = 22,
    parameter int         LINE_LENGTH  = 4,
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] MODE_BITS    = 8'hA0,
    parameter int         CS_GAP       = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pull,
    input  logic [PA-3:0] tag,
    input  logic          flush_all,
    output logic [3:0]    dread,
    output logic          wstrobe_d,
    output logic          busy,
    output logic          spi_cs_n,
    output logic          spi_sclk,
    output logic [3:0]    spi_io_out,
    output logic [3:0]    spi_io_oe,
    input  logic [3:0]    spi_io_in
);

    localparam int BUF_W = LINE_LENGTH * 8;

    state_e                 state_q;
    logic [PA-3:0]          r_tag_q;
    logic [39:0]            sh_q;       // outgoing bits still to be driven
    logic [BUF_W-1:0]       buf_q;
    logic [GAP_CNT_W-1:0]   gap_q;
    logic [DRAIN_CNT_W-1:0] drn_q;
    logic                   cs_n_q;
    logic                   busy_q;
    logic                   wstrobe_q;
    logic [3:0]             dread_q;
    logic [3:0]             io_out_q;
    logic [3:0]             io_oe_q;

    logic                   running;
    logic                   ph_en;
    logic                   ph_hi;
    logic                   ph_last;
    logic [PHASE_CNT_W-1:0] phase_len;
    logic [23:0]            req_addr;

    assign running  = state_q inside {CMD, ADDR, MODE, DUMMY, DATA};
    // A flush stops the SPI clock on the same edge that raises chip select.
    assign ph_en    = running && !flush_all;
    assign req_addr = 24'({tag, 2'b00});

    always_comb begin
        phase_len = PHASE_CNT_W'(1);
        case (state_q)
            CMD:     phase_len = PHASE_CNT_W'(CMD_BITS);
            ADDR:    phase_len = PHASE_CNT_W'(ADDR_NIBBLES);
            MODE:    phase_len = PHASE_CNT_W'(MODE_NIBBLES);
            DUMMY:   phase_len = PHASE_CNT_W'(DUMMY_CYCLES);
            DATA:    phase_len = PHASE_CNT_W'(NIBBLES_PER_LINE);
            default: phase_len = PHASE_CNT_W'(1);
        endcase
    end

    qspi_phase u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (ph_en),
        .len_i      (phase_len),
        .sclk_o     (spi_sclk),
        .phase_hi_o (ph_hi),
        .last_o     (ph_last)
    );

    // IO is updated only on the edge ending a high phase, i.e. at the start of
    // the next low phase, so the flash always sees stable data on its rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            r_tag_q   <= '0;
            sh_q      <= '0;
            buf_q     <= '0;
            gap_q     <= '0;
            drn_q     <= '0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            wstrobe_q <= 1'b0;
            dread_q   <= 4'h0;
            io_out_q  <= 4'h0;
            io_oe_q   <= 4'h0;
        end else if (flush_all && state_q != IDLE && state_q != GAP) begin
            state_q   <= GAP;
            gap_q     <= GAP_CNT_W'(CS_GAP);
            cs_n_q    <= 1'b1;
            io_oe_q   <= 4'h0;
            io_out_q  <= 4'h0;
            wstrobe_q <= 1'b0;
            dread_q   <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pull && gap_q == '0 && !flush_all) begin
                        r_tag_q  <= tag;
                        state_q  <= CMD;
                        cs_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        io_oe_q  <= 4'b0001;
                        io_out_q <= {3'b000, QSPI_CMD_FAST_READ_QUAD[7]};
                        // Command MSB goes out now; the rest is queued behind it.
                        sh_q     <= {QSPI_CMD_FAST_READ_QUAD[6:0], req_addr, MODE_BITS, 1'b0};
                    end
                end
                CMD: begin
                    if (ph_hi) begin
                        if (ph_last) begin
                            state_q  <= ADDR;
                            io_oe_q  <= 4'hF;
                            io_out_q <= sh_q[39:36];
                            sh_q     <= sh_q << 4;
                        end else begin
                            io_out_q <= {3'b000, sh_q[39]};
                            sh_q     <= sh_q << 1;
                        end
                    end
                end
                ADDR: begin
                    if (ph_hi) begin
                        io_out_q <= sh_q[39:36];
                        sh_q     <= sh_q << 4;
                        if (ph_last) begin
                            state_q <= MODE;
                        end
                    end
                end
                MODE: begin
                    if (ph_hi) begin
                        if (ph_last) begin
                            state_q  <= DUMMY;
                            io_oe_q  <= 4'h0;
                            io_out_q <= 4'h0;
                        end else begin
                            io_out_q <= sh_q[39:36];
                            sh_q     <= sh_q << 4;
                        end
                    end
                end
                DUMMY: begin
                    if (ph_last) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (ph_hi) begin
                        buf_q <= {buf_q[BUF_W-5:0], spi_io_in};
                        if (ph_last) begin
                            state_q <= DRAIN;
                            cs_n_q  <= 1'b1;
                            drn_q   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drn_q == '0) begin
                        // The line is only delivered if the cache still wants it.
                        if (pull && tag == r_tag_q) begin
                            wstrobe_q <= 1'b1;
                            dread_q   <= buf_q[BUF_W-1 -: 4];
                            buf_q     <= buf_q << 4;
                            drn_q     <= DRAIN_CNT_W'(1);
                        end else begin
                            state_q <= GAP;
                            gap_q   <= GAP_CNT_W'(CS_GAP);
                        end
                    end else if (drn_q == DRAIN_CNT_W'(NIBBLES_PER_LINE)) begin
                        wstrobe_q <= 1'b0;
                        dread_q   <= 4'h0;
                        state_q   <= GAP;
                        gap_q     <= GAP_CNT_W'(CS_GAP);
                    end else begin
                        dread_q <= buf_q[BUF_W-1 -: 4];
                        buf_q   <= buf_q << 4;
                        drn_q   <= drn_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q <= GAP_CNT_W'(1)) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dread      = dread_q;
    assign wstrobe_d  = wstrobe_q;
    assign busy       = busy_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_io_out = io_out_q;
    assign spi_io_oe  = io_oe_q;

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - self-checking bench for icache_fill with a behavioural quad-SPI flash
module tb_icache_fill;

    localparam int PA = 22;
    localparam int TW = PA - 2;
    localparam int D4 = 4;
    localparam int D6 = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pull, pull6;
    logic [TW-1:0] tag, tag6;
    logic          flush_all;
    logic [3:0]    dread, dread6;
    logic          wstrobe_d, wstrobe6;
    logic          busy, busy6;
    logic          spi_cs_n, spi_cs_n6;
    logic          spi_sclk, spi_sclk6;
    logic [3:0]    spi_io_out, spi_io_out6;
    logic [3:0]    spi_io_oe, spi_io_oe6;
    logic [3:0]    spi_io_in = 4'h0;
    logic [3:0]    spi_io_in6 = 4'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_fill #(.PA(PA), .DUMMY_CYCLES(D4)) dut (
        .clk(clk), .reset_n(reset_n), .pull(pull), .tag(tag), .flush_all(flush_all),
        .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy), .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );

    icache_fill #(.PA(PA), .DUMMY_CYCLES(D6)) dut6 (
        .clk(clk), .reset_n(reset_n), .pull(pull6), .tag(tag6), .flush_all(1'b0),
        .dread(dread6), .wstrobe_d(wstrobe6), .busy(busy6), .spi_cs_n(spi_cs_n6),
        .spi_sclk(spi_sclk6), .spi_io_out(spi_io_out6), .spi_io_oe(spi_io_oe6), .spi_io_in(spi_io_in6)
    );

    // Flash contents: the basic-fill word at 0x100, a deterministic scramble elsewhere.
    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (a == 24'h000100) return 32'h12345678;
        return {a[7:0] ^ 8'h5C, a} ^ 32'h9E3779B9;
    endfunction

    // Behavioural flash: counts sclk periods since cs_n fell, decodes the
    // command/address/mode fields and drives data during the data periods.
    int          hc = 0;
    logic [7:0]  fl_cmd;
    logic [23:0] fl_addr;
    logic [7:0]  fl_mode;
    int          fl_oe_err = 0;
    logic [23:0] fl_txn[$];
    logic [31:0] fw;

    always @(negedge clk) begin
        if (spi_cs_n) begin
            hc = 0;
        end else if (spi_sclk) begin
            if (hc < 8) begin
                fl_cmd = {fl_cmd[6:0], spi_io_out[0]};
                if (spi_io_oe !== 4'b0001) fl_oe_err++;
            end else if (hc < 14) begin
                fl_addr = {fl_addr[19:0], spi_io_out};
                if (spi_io_oe !== 4'hF) fl_oe_err++;
            end else if (hc < 16) begin
                fl_mode = {fl_mode[3:0], spi_io_out};
                if (spi_io_oe !== 4'hF) fl_oe_err++;
            end else begin
                if (spi_io_oe !== 4'h0) fl_oe_err++;
                if (hc >= 16 + D4 && hc < 24 + D4) begin
                    fw = mem_word(fl_addr);
                    spi_io_in = fw[31 - 4*(hc - 16 - D4) -: 4];
                end
                if (hc == 23 + D4) fl_txn.push_back(fl_addr);
            end
            hc++;
        end
    end

    int          hc6 = 0;
    logic [31:0] w6 = 32'hCAFE1234;
    always @(negedge clk) begin
        if (spi_cs_n6) begin
            hc6 = 0;
        end else if (spi_sclk6) begin
            if (hc6 >= 16 + D6 && hc6 < 24 + D6) spi_io_in6 = w6[31 - 4*(hc6 - 16 - D6) -: 4];
            hc6++;
        end
    end

    // Output monitors, sampled 1 time unit after each rising edge.
    int         s_cyc[$];
    logic [3:0] s_dat[$];
    int         cs_fall[$];
    int         cs_gap[$];
    int         cs_run = 0;
    logic       cs_prev = 1'b1;
    int         s6_cyc[$];
    logic [3:0] s6_dat[$];
    int         cs6_fall[$];
    logic       cs6_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (wstrobe_d) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(dread);
        end
        if (!spi_cs_n && cs_prev) begin
            cs_fall.push_back(cyc);
            cs_gap.push_back(cs_run);
        end
        cs_run  = spi_cs_n ? cs_run + 1 : 0;
        cs_prev = spi_cs_n;
        if (wstrobe6) begin
            s6_cyc.push_back(cyc);
            s6_dat.push_back(dread6);
        end
        if (!spi_cs_n6 && cs6_prev) cs6_fall.push_back(cyc);
        cs6_prev = spi_cs_n6;
    end

    task automatic clear_logs();
        s_cyc.delete(); s_dat.delete(); cs_fall.delete(); cs_gap.delete();
        fl_txn.delete(); fl_oe_err = 0;
        s6_cyc.delete(); s6_dat.delete(); cs6_fall.delete();
    endtask

    task automatic wait_strobes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && s_cyc.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cyc);
        @(negedge clk);
        for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    endtask

    // Collects the burst starting at strobe index base.
    task automatic get_burst(input int base, output int n, output int first, output int last,
                             output logic [31:0] word);
        n     = s_cyc.size() - base;
        first = (n > 0) ? s_cyc[base] : -1;
        last  = (n > 0) ? s_cyc[s_cyc.size() - 1] : -1;
        word  = '0;
        for (int i = base; i < s_cyc.size() && i < base + 8; i++) word = {word[27:0], s_dat[i]};
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pull = 1'b0; pull6 = 1'b0; flush_all = 1'b0; tag = '0; tag6 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (wstrobe_d !== 1'b0) begin n_fail++; $display("FAIL reset_wstrobe: got %b want 0", wstrobe_d); end
        n_checks++; if (dread !== 4'h0) begin n_fail++; $display("FAIL reset_dread: got %h want 0", dread); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        n_checks++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        n_checks++; if (spi_io_oe !== 4'h0) begin n_fail++; $display("FAIL reset_oe: got %h want 0", spi_io_oe); end
        n_checks++; if (spi_io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0", spi_io_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, spi_cs_n} !== 2'b01) begin n_fail++; $display("FAIL reset_idle_hold: got %b want 01", {busy, spi_cs_n}); end
    endtask

    task automatic test_basic();
        int t, n, first, last; logic [31:0] word;
        clear_logs();
        tag = 20'h00040; pull = 1'b1; t = cyc + 1;
        wait_strobes(8, 120);
        pull = 1'b0;
        wait_idle(40);
        get_burst(0, n, first, last, word);
        n_checks++; if (cs_fall.size() < 1 || cs_fall[0] != t) begin n_fail++; $display("FAIL basic_cs_fall: got %0d want %0d", (cs_fall.size() > 0) ? cs_fall[0] - t : -1, 0); end
        n_checks++; if (fl_cmd !== 8'hEB) begin n_fail++; $display("FAIL basic_cmd: got %h want eb", fl_cmd); end
        n_checks++; if (fl_addr !== 24'h000100) begin n_fail++; $display("FAIL basic_addr: got %h want 000100", fl_addr); end
        n_checks++; if (fl_mode !== 8'hA0) begin n_fail++; $display("FAIL basic_mode: got %h want a0", fl_mode); end
        n_checks++; if (fl_oe_err != 0) begin n_fail++; $display("FAIL basic_oe: got %0d bad periods want 0", fl_oe_err); end
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", n); end
        n_checks++; if (first != t + 57) begin n_fail++; $display("FAIL basic_first: got t+%0d want t+57", first - t); end
        n_checks++; if (last != t + 64) begin n_fail++; $display("FAIL basic_last: got t+%0d want t+64", last - t); end
        n_checks++; if (word !== 32'h12345678) begin n_fail++; $display("FAIL basic_data: got %h want 12345678", word); end
    endtask

    task automatic test_random();
        int t, n, first, last; logic [31:0] word; logic [23:0] a;
        for (int it = 0; it < 5; it++) begin
            clear_logs();
            tag = TW'($urandom); a = 24'({tag, 2'b00});
            pull = 1'b1; t = cyc + 1;
            wait_strobes(8, 120);
            pull = 1'b0;
            wait_idle(40);
            get_burst(0, n, first, last, word);
            n_checks++; if (n != 8 || first != t + 57) begin n_fail++; $display("FAIL random_timing[%0d]: got n=%0d first=t+%0d want n=8 first=t+57", it, n, first - t); end
            n_checks++; if (word !== mem_word(a)) begin n_fail++; $display("FAIL random_data[%0d]: got %h want %h", it, word, mem_word(a)); end
            n_checks++; if (fl_txn.size() != 1 || fl_txn[0] !== a || fl_oe_err != 0) begin n_fail++; $display("FAIL random_bus[%0d]: got txns=%0d oe_err=%0d want 1 txn to %h", it, fl_txn.size(), fl_oe_err, a); end
        end
    endtask

    task automatic test_back_to_back();
        int n, first, last; logic [31:0] word;
        clear_logs();
        tag = 20'h00040; pull = 1'b1;
        wait_strobes(8, 120);
        tag = 20'h00041;
        wait_strobes(16, 200);
        pull = 1'b0;
        wait_idle(40);
        get_burst(8, n, first, last, word);
        n_checks++; if (cs_fall.size() != 2) begin n_fail++; $display("FAIL b2b_txns: got %0d cs falls want 2", cs_fall.size()); end
        n_checks++; if (cs_gap.size() < 2 || cs_gap[1] < 2) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want >=2", (cs_gap.size() > 1) ? cs_gap[1] : -1); end
        n_checks++; if (fl_txn.size() < 2 || fl_txn[1] !== 24'h000104) begin n_fail++; $display("FAIL b2b_addr: got %h want 000104", (fl_txn.size() > 1) ? fl_txn[1] : 24'hx); end
        n_checks++; if (n != 8 || cs_fall.size() < 2 || first != cs_fall[1] + 57) begin n_fail++; $display("FAIL b2b_timing: got n=%0d first=%0d want 8 at second cs fall+57", n, first); end
        n_checks++; if (word !== mem_word(24'h000104)) begin n_fail++; $display("FAIL b2b_data: got %h want %h", word, mem_word(24'h000104)); end
    endtask

    task automatic test_tag_change();
        int t, n, first, last; logic [31:0] word; logic [TW-1:0] ta, tb;
        clear_logs();
        ta = TW'($urandom); tb = ta + TW'($urandom_range(1, 1000));
        tag = ta; pull = 1'b1; t = cyc + 1;
        while (cyc < t + 50) @(negedge clk);
        tag = tb;
        wait_strobes(8, 200);
        pull = 1'b0;
        wait_idle(40);
        get_burst(0, n, first, last, word);
        n_checks++; if (cs_fall.size() != 2) begin n_fail++; $display("FAIL tagchg_txns: got %0d cs falls want 2", cs_fall.size()); end
        n_checks++; if (n != 8 || cs_fall.size() < 2 || first != cs_fall[1] + 57) begin n_fail++; $display("FAIL tagchg_strobes: got n=%0d first=%0d want 8 from second fill only", n, first); end
        n_checks++; if (word !== mem_word(24'({tb, 2'b00}))) begin n_fail++; $display("FAIL tagchg_data: got %h want %h", word, mem_word(24'({tb, 2'b00}))); end
        n_checks++; if (fl_txn.size() != 2 || fl_txn[0] !== 24'({ta, 2'b00}) || fl_txn[1] !== 24'({tb, 2'b00})) begin n_fail++; $display("FAIL tagchg_addr: got %0d txns want 2 (old then new tag)", fl_txn.size()); end
    endtask

    task automatic test_pull_drop();
        int t;
        clear_logs();
        tag = TW'($urandom); pull = 1'b1; t = cyc + 1;
        while (cyc < t + 30) @(negedge clk);
        pull = 1'b0;
        wait_idle(100);
        n_checks++; if (s_cyc.size() != 0) begin n_fail++; $display("FAIL pulldrop_strobes: got %0d want 0", s_cyc.size()); end
        n_checks++; if (fl_txn.size() != 1) begin n_fail++; $display("FAIL pulldrop_completed: got %0d txns want 1", fl_txn.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulldrop_busy: got %b want 0", busy); end
    endtask

    task automatic test_flush();
        int t;
        clear_logs();
        tag = TW'($urandom); pull = 1'b1; t = cyc + 1;
        while (cyc < t + 20) @(negedge clk);
        flush_all = 1'b1; pull = 1'b0;
        @(negedge clk);
        flush_all = 1'b0;
        n_checks++; if ({spi_cs_n, spi_io_oe, wstrobe_d} !== {1'b1, 4'h0, 1'b0}) begin n_fail++; $display("FAIL flush_next_cycle: got cs_n=%b oe=%h wstrobe=%b want 1 0 0", spi_cs_n, spi_io_oe, wstrobe_d); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_in_gap: got %b want 1", busy); end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        repeat (80) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        n_checks++; if (s_cyc.size() != 0 || fl_txn.size() != 0) begin n_fail++; $display("FAIL flush_no_data: got strobes=%0d txns=%0d want 0 0", s_cyc.size(), fl_txn.size()); end
    endtask

    task automatic test_flush_idle();
        clear_logs();
        pull = 1'b1; flush_all = 1'b1;
        @(negedge clk);
        pull = 1'b0; flush_all = 1'b0;
        n_checks++; if ({spi_cs_n, busy} !== 2'b10) begin n_fail++; $display("FAIL flush_idle_no_start: got cs_n=%b busy=%b want 1 0", spi_cs_n, busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (cs_fall.size() != 0) begin n_fail++; $display("FAIL flush_idle_cs: got %0d cs falls want 0", cs_fall.size()); end
    endtask

    task automatic test_async_reset();
        int t, n, first, last; logic [31:0] word; logic [23:0] a;
        clear_logs();
        tag = TW'($urandom); a = 24'({tag, 2'b00});
        pull = 1'b1;
        wait_strobes(3, 120);
        n_checks++; if (wstrobe_d !== 1'b1) begin n_fail++; $display("FAIL areset_pre_strobe: got %b want 1", wstrobe_d); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if ({wstrobe_d, busy, spi_cs_n, spi_sclk, dread, spi_io_out, spi_io_oe} !== {1'b0, 1'b0, 1'b1, 1'b0, 12'h000}) begin n_fail++; $display("FAIL areset_outputs: got ws=%b busy=%b cs_n=%b sclk=%b dread=%h io=%h oe=%h want reset values", wstrobe_d, busy, spi_cs_n, spi_sclk, dread, spi_io_out, spi_io_oe); end
        @(negedge clk);
        clear_logs();
        reset_n = 1'b1; t = cyc + 1;
        wait_strobes(8, 120);
        pull = 1'b0;
        wait_idle(40);
        get_burst(0, n, first, last, word);
        n_checks++; if (n != 8 || first != t + 57 || last != t + 64) begin n_fail++; $display("FAIL areset_refill_timing: got n=%0d first=t+%0d last=t+%0d want 8 57 64", n, first - t, last - t); end
        n_checks++; if (word !== mem_word(a)) begin n_fail++; $display("FAIL areset_refill_data: got %h want %h", word, mem_word(a)); end
    endtask

    task automatic test_dummy6();
        int t;
        logic [31:0] word;
        clear_logs();
        tag6 = TW'($urandom); pull6 = 1'b1; t = cyc + 1;
        for (int i = 0; i < 140 && s6_cyc.size() < 8; i++) @(negedge clk);
        pull6 = 1'b0;
        repeat (20) @(negedge clk);
        word = '0;
        for (int i = 0; i < s6_cyc.size() && i < 8; i++) word = {word[27:0], s6_dat[i]};
        n_checks++; if (s6_cyc.size() != 8 || s6_cyc[0] != t + 61) begin n_fail++; $display("FAIL dummy6_timing: got n=%0d first=t+%0d want 8 at t+61", s6_cyc.size(), (s6_cyc.size() > 0) ? s6_cyc[0] - t : -1); end
        n_checks++; if (word !== 32'hCAFE1234) begin n_fail++; $display("FAIL dummy6_data: got %h want cafe1234", word); end
        n_checks++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL dummy6_busy: got %b want 0", busy6); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_tag_change();
        test_pull_drop();
        test_flush();
        test_flush_idle();
        test_async_reset();
        test_dummy6();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
